fmap_stream_reader: RTL and testbench
=====================================

Name: fmap_stream_reader

Overview:
- Producer end of the pixel valid/ready stream consumed by the depthwise and line-buffer stages.
- On `start`, reads one H x W single-channel feature-map plane from a synchronous-read activation SRAM and emits it in raster order.
- A 2-entry skid FIFO hides the 1-cycle SRAM read latency, so backpressure never drops or duplicates a pixel.
- Sustains 1 pixel/cycle when `out_ready` stays high.

Parameters:
- DATA_W, 8, pixel width (signed int8 activations).
- MAX_IMG_W, 224, maximum plane width.
- MAX_IMG_H, 224, maximum plane height.
- ADDR_W, 16, SRAM word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a frame; honoured only in IDLE.
- cfg_img_h  in  $clog2(MAX_IMG_H)  plane height; latched at start.
- cfg_img_w  in  $clog2(MAX_IMG_W)  plane width; latched at start.
- cfg_base_addr  in  ADDR_W  word address of pixel (0,0); latched at start.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  ADDR_W  SRAM read address.
- mem_rd_data  in  DATA_W  signed read data; valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  pixel available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  signed pixel.
- out_last  out  1  high with the final pixel of the frame.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  single-cycle pulse at frame completion.

Behaviour:
- Reset (async, rst=1): state=IDLE; FIFO empty; in-flight flag cleared; counters cleared. Outputs mem_rd_en, out_valid, out_last, busy and done are 0; mem_rd_addr=0; out_data=0.
- IDLE:
  - start=1 and both dims nonzero: latch config, total=H*W, issue count=0, go to RUN.
  - start=1 with H==0 or W==0: no reads; done=1 on the next cycle; stay IDLE.
- RUN:
  - Issue condition, all required: issued < total, and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready in the same cycle.
  - On issue: mem_rd_en=1, mem_rd_addr = base + issued (linear; row*W+col is implied). Address adds wrap modulo 2^ADDR_W.
  - After the last issue, go to DRAIN.
- DRAIN: wait for FIFO empty and no read in flight. Then done=1 for one cycle and return to IDLE. busy=0 in the done cycle.
- Return data: mem_rd_data is written into the FIFO at the end of the cycle after mem_rd_en. out_valid = FIFO non-empty. out_data = FIFO head.
- Simultaneous FIFO push and pop is legal at any occupancy the credit rule allows. The FIFO never overflows, because the credit rule guarantees at most 2 entries plus in-flight reads.
- out_last = out_valid & (head is pixel index total-1). Implement with a popped-pixel counter compared against total-1.
- Latency: start sampled at edge 0 → mem_rd_en in cycle 1 → out_valid in cycle 3. Steady-state 1 pixel/cycle with out_ready=1.
- Backpressure:
  - out_ready=0 keeps out_valid/out_data/out_last stable.
  - Reads stop once 2 pixels are held or in flight, and resume the cycle a pop frees a credit.
- start while busy is ignored; latched config is unchanged.
- Arithmetic:
  - total width is $clog2(MAX_IMG_H)+$clog2(MAX_IMG_W) bits.
  - issued and popped counters use the same width.
  - No signed arithmetic on data; pass-through only.
- Reset mid-frame: immediate abort to the reset state. A read already issued is discarded, and its mem_rd_data is ignored in the following cycle.

Test Plan:
- H=4, W=4, base=0x0100, out_ready=1, SRAM[a]=a[7:0] → mem_rd_addr 0x0100..0x010F on cycles 1..16; out_data 0x00..0x0F on cycles 3..18; out_last only on cycle 18; done on cycle 19.
- Same frame, out_ready held 0 for cycles 0..12 then 1 → exactly 2 reads (0x0100, 0x0101) before stall; out_data stays 0x00 while stalled; all 16 pixels delivered in order with no gap or duplicate.
- H=3, W=5, base=0xFFFE, random 50% out_ready → 15 pixels in order; addresses wrap 0xFFFE, 0xFFFF, 0x0000..; checker asserts fifo_count+inflight ≤ 2 every cycle; exactly one out_last.
- H=0, W=7, start pulse → no mem_rd_en ever; done=1 one cycle later; busy stays 0.
- Start a 4x4 frame, pulse start with H=2, W=2 at cycle 5 → ignored; 16 pixels still emitted.
- Assert rst at cycle 6 of a 4x4 frame → all outputs 0 asynchronously, state IDLE; a new 2x2 start afterwards yields 4 correct pixels and done.

Source files
------------

// File: rtl/fmap_stream_reader.sv
// fmap_stream_reader: reads one H x W single-channel feature-map plane from a
// synchronous-read activation SRAM and streams it out in raster order over a
// valid/ready interface. A 2-entry skid FIFO absorbs the 1-cycle read latency
// so backpressure never drops or duplicates a pixel; 1 pixel/cycle when
// out_ready stays high.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a frame (honoured only when idle)
//   cfg_img_h/w       plane height/width, latched at start
//   cfg_base_addr     word address of pixel (0,0), latched at start
//   mem_rd_en/addr    SRAM read strobe and address
//   mem_rd_data       SRAM read data, valid 1 cycle after mem_rd_en
//   out_valid/ready   pixel stream handshake
//   out_data          pixel value (head of skid FIFO)
//   out_last          marks the final pixel of the frame
//   busy              frame in progress (low in the done cycle)
//   done              single-cycle frame-completion pulse
module fmap_stream_reader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_IMG_W = 224,
    parameter int unsigned MAX_IMG_H = 224,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_IMG_H)-1:0]  cfg_img_h,
    input  logic [$clog2(MAX_IMG_W)-1:0]  cfg_img_w,
    input  logic [ADDR_W-1:0]             cfg_base_addr,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    input  logic [DATA_W-1:0]             mem_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned H_W   = $clog2(MAX_IMG_H);
    localparam int unsigned W_W   = $clog2(MAX_IMG_W);
    localparam int unsigned CNT_W = H_W + W_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  popped_q;
    logic [ADDR_W-1:0] base_q;
    logic              inflight_q;
    logic              zero_done_q;

    logic [DATA_W-1:0] fifo_mem_q [0:1];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;

    logic       pop;
    logic       push;
    logic [2:0] occ;
    logic       issue;
    logic       start_frame;
    logic       start_zero;

    // Stream side: FIFO head drives the output; zero while empty.
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && (popped_q == total_q - CNT_W'(1));
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q;

    // Credits: held + in-flight pixels after this cycle's pop must stay below 2.
    assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue = (state_q == S_RUN) && (issued_q < total_q) && (occ < 3'd2);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and read-port / status decode.
    always_comb begin
        state_d     = state_q;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        busy        = 1'b0;
        done        = zero_done_q;
        start_frame = 1'b0;
        start_zero  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((cfg_img_h != '0) && (cfg_img_w != '0)) begin
                        start_frame = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        start_zero = 1'b1;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (issue) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = base_q + ADDR_W'(issued_q);
                    if (issued_q == total_q - CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame configuration and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q     <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            base_q      <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_zero;
            inflight_q  <= mem_rd_en;
            if (start_frame) begin
                total_q  <= CNT_W'(cfg_img_h) * CNT_W'(cfg_img_w);
                base_q   <= cfg_base_addr;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + CNT_W'(1);
                end
                if (pop) begin
                    popped_q <= popped_q + CNT_W'(1);
                end
            end
        end
    end

    // 2-entry skid FIFO; push is the read return one cycle after mem_rd_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= mem_rd_data;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Bench for fmap_stream_reader: SRAM model returns addr[7:0]; a frame-level
// model (expected address/pixel index sequences) is checked every cycle,
// plus hand-computed cycle numbers for the directed cases.
module tb_fmap_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_img_h = '0;
    logic [7:0]  cfg_img_w = '0;
    logic [15:0] cfg_base_addr = '0;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [7:0]  mem_rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    fmap_stream_reader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_img_h     (cfg_img_h),
        .cfg_img_w     (cfg_img_w),
        .cfg_base_addr (cfg_base_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: word at address a holds a[7:0].
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Frame model state.
    int          exp_total;
    logic [15:0] exp_base;
    int          iss_idx, pop_idx;
    int          rd_count, first_rd, first_valid, last_cyc, last_cnt;
    int          done_cnt, done_cyc;
    bit          busy_seen, held, h_last;
    logic [7:0]  h_data;

    logic [31:0] ready_pat = 32'b1011_0010_0110_1101_0100_1110_0011_0101;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_init(input int h, input int w, input logic [15:0] base);
        exp_total   = h * w;
        exp_base    = base;
        iss_idx     = 0;
        pop_idx     = 0;
        rd_count    = 0;
        first_rd    = -1;
        first_valid = -1;
        last_cyc    = -1;
        last_cnt    = 0;
        done_cnt    = 0;
        done_cyc    = -1;
        busy_seen   = 0;
        held        = 0;
    endtask

    // Per-cycle compare against the frame model (called at the falling edge).
    task automatic sample(input int k);
        logic [15:0] a;
        if (mem_rd_en) begin
            a = exp_base + 16'(iss_idx);
            chk("rd_in_range", int'(iss_idx < exp_total), 1);
            chk("rd_addr", int'(mem_rd_addr), int'(a));
            if (rd_count == 0) first_rd = k;
            rd_count++;
            iss_idx++;
        end
        if (held) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'(h_data));
            chk("hold_last", int'(out_last), int'(h_last));
        end
        if (out_valid) begin
            if (first_valid < 0) first_valid = k;
            if (out_ready) begin
                a = exp_base + 16'(pop_idx);
                chk("pix_data", int'(out_data), int'(a[7:0]));
                chk("pix_last", int'(out_last), int'(pop_idx == exp_total - 1));
                if (out_last) begin
                    last_cnt++;
                    last_cyc = k;
                end
                pop_idx++;
                held = 0;
            end else begin
                held   = 1;
                h_data = out_data;
                h_last = out_last;
            end
        end else begin
            chk("last_without_valid", int'(out_last), 0);
        end
        chk("credit_le_2", int'((iss_idx - pop_idx) <= 2), 1);
        if (done) begin
            done_cnt++;
            done_cyc = k;
            chk("busy_in_done", int'(busy), 0);
        end
        if (busy) busy_seen = 1;
    endtask

    // mode: 0 ready=1, 1 stall until cycle 13, 2 ready pattern,
    //       3 ignored start at cycle 5, 4 async reset at cycle 6
    task automatic run_frame(input int h, input int w, input logic [15:0] base, input int mode);
        int  k;
        bit  fin;
        model_init(h, w, base);
        cfg_img_h     = 8'(h);
        cfg_img_w     = 8'(w);
        cfg_base_addr = base;
        out_ready     = (mode != 1);
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k     = 1;
        fin   = 0;
        while (!fin) begin
            if (mode == 1) out_ready = (k >= 13);
            if (mode == 2) out_ready = ready_pat[k % 32];
            if (mode == 3) begin
                if (k == 5) begin
                    start     = 1'b1;
                    cfg_img_h = 8'd2;
                    cfg_img_w = 8'd2;
                end else begin
                    start = 1'b0;
                end
            end
            if (mode == 4 && k == 6) begin
                chk("busy_before_rst", int'(busy), 1);
                rst = 1'b1;
                #1;
                chk("rst_rd_en", int'(mem_rd_en), 0);
                chk("rst_rd_addr", int'(mem_rd_addr), 0);
                chk("rst_valid", int'(out_valid), 0);
                chk("rst_data", int'(out_data), 0);
                chk("rst_last", int'(out_last), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            sample(k);
            if (mode == 1 && k == 12) begin
                chk("stall_reads", rd_count, 2);
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), 8'h00);
            end
            if (done_cnt > 0) fin = 1;
            if (k >= 400) begin
                chk("frame_timeout", 0, 1);
                fin = 1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        // Two trailing cycles: no extra reads, pixels or done pulses.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sample(k);
            @(posedge clk);
            #1;
            k++;
        end
        chk("reads_total", rd_count, exp_total);
        chk("pixels_total", pop_idx, exp_total);
        chk("last_count", last_cnt, (exp_total > 0) ? 1 : 0);
        chk("done_count", done_cnt, 1);
        chk("done_after_last", int'(exp_total == 0 || done_cyc > last_cyc), 1);
    endtask

    initial begin
        // Reset state.
        #1;
        chk("reset_rd_en", int'(mem_rd_en), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_data", int'(out_data), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 4x4 at full rate: cycle-exact latency.
        run_frame(4, 4, 16'h0100, 0);
        chk("t1_first_rd_cycle", first_rd, 1);
        chk("t1_first_valid_cycle", first_valid, 3);
        chk("t1_last_cycle", last_cyc, 18);
        chk("t1_done_cycle", done_cyc, 19);

        // 4x4 with out_ready low through cycle 12.
        run_frame(4, 4, 16'h0100, 1);

        // 3x5 wrapping the address space under a ready pattern.
        run_frame(3, 5, 16'hFFFE, 2);

        // Zero-height frame: done next cycle, nothing read, never busy.
        run_frame(0, 7, 16'h0200, 0);
        chk("t4_done_cycle", done_cyc, 1);
        chk("t4_busy_seen", int'(busy_seen), 0);

        // Start while busy is ignored.
        run_frame(4, 4, 16'h0100, 3);

        // Reset mid-frame, then a clean 2x2 frame.
        run_frame(4, 4, 16'h0100, 4);
        run_frame(2, 2, 16'h0040, 0);
        chk("t6_first_valid_cycle", first_valid, 3);
        chk("t6_done_cycle", done_cyc, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
